// File: rtl/substitution_layer_iter_if.sv
// Start/done handshake bundle between the permutation control and the folded S-box layer.
// Lane x0 is state[0] through x4 at state[4]; bit i of every lane forms S-box column i.
interface substitution_layer_iter_if;
  logic             start_i;
  logic             en_i;
  logic [4:0][63:0] state_i;
  logic [4:0][63:0] state_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, en_i, state_i,
    input  state_o, busy_o, done_o
  );

  modport slave (
    input  start_i, en_i, state_i,
    output state_o, busy_o, done_o
  );
endinterface

// File: rtl/substitution_layer_iter.sv
// Folded ASCON substitution layer: COLS_PER_CYCLE S-box columns per enabled cycle, 64/COLS_PER_CYCLE slices.
// Latency NB_SLICES+1 edges from start to done with en_i held high; en_i=0 freezes a busy run.
module substitution_layer_iter #(
  parameter int COLS_PER_CYCLE = 8
) (
  input logic                  clock_i,
  input logic                  reset_i,
  substitution_layer_iter_if.slave bus
);

  localparam int NB_SLICES = (COLS_PER_CYCLE == 0) ? 1 : 64 / COLS_PER_CYCLE;
  localparam int CNT_W     = (NB_SLICES > 1) ? $clog2(NB_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NB_SLICES - 1);

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  generate
    if (COLS_PER_CYCLE <= 0 || (64 % COLS_PER_CYCLE) != 0) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be a non-zero divisor of 64");
    end
  endgenerate

  typedef enum logic [0:0] {IDLE, BUSY} fsm_t;

  fsm_t             fsm_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0][63:0] state_q;
  logic [4:0][63:0] state_d;
  logic             busy_q;
  logic             done_q;

  // Only the current slice is rewritten; every other column passes through unchanged.
  always_comb begin
    logic [5:0] col_idx;
    logic [4:0] col_in;
    logic [4:0] col_out;
    int         base;
    state_d = state_q;
    col_idx = '0;
    col_in  = '0;
    col_out = '0;
    base    = int'(cnt_q) * COLS_PER_CYCLE;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_idx = 6'(base + j);
      col_in  = {state_q[0][col_idx], state_q[1][col_idx], state_q[2][col_idx],
                 state_q[3][col_idx], state_q[4][col_idx]};
      col_out = SBOX[col_in];
      state_d[0][col_idx] = col_out[4];
      state_d[1][col_idx] = col_out[3];
      state_d[2][col_idx] = col_out[2];
      state_d[3][col_idx] = col_out[1];
      state_d[4][col_idx] = col_out[0];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            state_q <= bus.state_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            fsm_q   <= BUSY;
          end
        end
        BUSY: begin
          // start_i is deliberately not looked at here: a run is never restarted or queued.
          if (bus.en_i) begin
            state_q <= state_d;
            if (cnt_q == LAST_SLICE) begin
              cnt_q  <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              fsm_q  <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.state_o = state_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_substitution_layer_iter.sv
// Bench for the folded S-box layer: three instances (8, 1 and 64 columns per cycle) share one stimulus,
// each checked every cycle against a column-level reference plus hand-computed literals.
module tb_substitution_layer_iter;

  typedef logic [4:0][63:0] state_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   start = 1'b0;
  logic   en = 1'b1;
  state_t st_in = '0;

  logic [2:0] done_v;
  logic [2:0] busy_v;
  state_t     so_v [3];
  int         lat  [3];

  int checks = 0;
  int failures = 0;

  localparam byte SB [32] = '{
    8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
    8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
    8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
    8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17
  };

  always #5 clk = ~clk;

  function automatic logic [4:0] col(input state_t s, input int i);
    return {s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]};
  endfunction

  function automatic state_t layer(input state_t s);
    state_t     r;
    logic [4:0] o;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      o = SB[col(s, i)][4:0];
      for (int l = 0; l < 5; l++) r[l][i] = o[4-l];
    end
    return r;
  endfunction

  // Columns below n have been substituted, the rest still hold the sampled input.
  function automatic state_t mix(input state_t a, input state_t b, input int n);
    state_t r;
    for (int i = 0; i < 64; i++)
      for (int l = 0; l < 5; l++) r[l][i] = (i < n) ? b[l][i] : a[l][i];
    return r;
  endfunction

  task automatic chk(input bit ok, input string name, input string act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%s required=%s", name, act, req);
    end
  endtask

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int C = (g == 0) ? 8 : (g == 1) ? 1 : 64;

      substitution_layer_iter_if bus ();
      assign bus.start_i = start;
      assign bus.en_i    = en;
      assign bus.state_i = st_in;
      assign done_v[g]   = bus.done_o;
      assign busy_v[g]   = bus.busy_o;
      assign so_v[g]     = bus.state_o;

      substitution_layer_iter #(.COLS_PER_CYCLE(C)) u_dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
      );

      state_t m_in = '0;
      state_t m_gold = '0;
      int     m_k = 0;
      bit     m_busy = 1'b0;
      bit     m_done = 1'b0;
      state_t m_exp;

      always @(posedge clk or posedge rst) begin
        if (rst) begin
          m_in <= '0; m_gold <= '0; m_k <= 0; m_busy <= 1'b0; m_done <= 1'b0;
        end else if (!m_busy) begin
          m_done <= 1'b0;
          if (start) begin
            m_in <= st_in; m_gold <= layer(st_in); m_k <= 0; m_busy <= 1'b1;
          end
        end else if (en) begin
          m_k <= m_k + 1;
          if ((m_k + 1) * C == 64) begin
            m_busy <= 1'b0; m_done <= 1'b1;
          end
        end
      end

      always @(negedge clk) begin
        m_exp = mix(m_in, m_gold, m_k * C);
        chk(bus.busy_o === m_busy, $sformatf("busy_c%0d", C),
            $sformatf("%b", bus.busy_o), $sformatf("%b", m_busy));
        chk(bus.done_o === m_done, $sformatf("done_c%0d", C),
            $sformatf("%b", bus.done_o), $sformatf("%b", m_done));
        chk(bus.state_o === m_exp, $sformatf("state_c%0d", C),
            $sformatf("%h", bus.state_o), $sformatf("%h", m_exp));
      end
    end
  endgenerate

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input state_t v);
    bit all_seen;
    st_in = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) lat[k] = 0;
    for (int c = 1; c <= 150; c++) begin
      all_seen = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (lat[k] == 0 && done_v[k]) lat[k] = c;
        if (lat[k] == 0) all_seen = 1'b0;
      end
      if (all_seen) break;
      tick();
    end
  endtask

  task automatic check_lat(input string name);
    int exp_lat [3];
    exp_lat = '{9, 65, 2};
    for (int k = 0; k < 3; k++)
      chk(lat[k] == exp_lat[k], $sformatf("%s_latency_%0d", name, k),
          $sformatf("%0d", lat[k]), $sformatf("%0d", exp_lat[k]));
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy_v != 3'b000 && c < 200) begin
      tick();
      c++;
    end
    chk(busy_v == 3'b000, "wait_idle", $sformatf("%b", busy_v), "000");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    state_t zero_res, ones_res, vec4;
    int c;
    zero_res = '0;
    zero_res[2] = '1;
    ones_res = '1;
    ones_res[1] = '0;
    vec4[0] = 64'h80400c0600000000;
    vec4[1] = 64'h0001020304050607;
    vec4[2] = 64'h08090a0b0c0d0eff;
    vec4[3] = 64'h0011223344556677;
    vec4[4] = 64'h8899aabbccddeeff;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    chk(layer('0) == zero_res, "model_zero", "model", "x2 ones");
    chk(layer('1) == ones_res, "model_ones", "model", "x1 zero");
    chk(col(layer(vec4), 63) == 5'b10011, "model_col63",
        $sformatf("%b", col(layer(vec4), 63)), "10011");

    run('0);
    check_lat("zeros");
    chk(so_v[0] == zero_res, "zeros_result", $sformatf("%h", so_v[0]), $sformatf("%h", zero_res));
    wait_idle();

    run('1);
    check_lat("ones");
    chk(so_v[0] == ones_res, "ones_result", $sformatf("%h", so_v[0]), $sformatf("%h", ones_res));
    wait_idle();

    run(vec4);
    check_lat("vec4");
    for (int k = 0; k < 3; k++)
      chk(col(so_v[k], 63) == 5'b10011, $sformatf("vec4_col63_%0d", k),
          $sformatf("%b", col(so_v[k], 63)), "10011");
    wait_idle();

    // Three-cycle stall plus a start pulse that must be ignored by the busy 8-column instance.
    st_in = '0; start = 1'b1; tick(); start = 1'b0; c = 1;
    tick(); c++;
    st_in = '1; start = 1'b1; en = 1'b0;
    tick(); c++;
    start = 1'b0;
    tick(); c++;
    tick(); c++;
    en = 1'b1;
    while (!done_v[0] && c < 100) begin
      tick();
      c++;
    end
    chk(c == 12, "stall_latency", $sformatf("%0d", c), "12");
    chk(so_v[0] == zero_res, "stall_result", $sformatf("%h", so_v[0]), $sformatf("%h", zero_res));

    st_in = vec4; start = 1'b1; tick(); start = 1'b0; c = 1;
    chk(busy_v[0] == 1'b1 && done_v[0] == 1'b0, "restart_in_done",
        $sformatf("busy=%b done=%b", busy_v[0], done_v[0]), "busy=1 done=0");
    while (!done_v[0] && c < 100) begin
      tick();
      c++;
    end
    chk(c == 9, "restart_latency", $sformatf("%0d", c), "9");
    chk(col(so_v[0], 63) == 5'b10011, "restart_col63", $sformatf("%b", col(so_v[0], 63)), "10011");
    wait_idle();

    // Reset asserted mid-clock while slice 4 of the 8-column instance is pending.
    st_in = vec4; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      chk(so_v[k] == '0 && busy_v[k] == 1'b0 && done_v[k] == 1'b0, $sformatf("async_reset_%0d", k),
          $sformatf("busy=%b done=%b state=%h", busy_v[k], done_v[k], so_v[k]), "all zero");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    chk(done_v == 3'b000, "no_done_after_reset", $sformatf("%b", done_v), "000");

    run('1);
    check_lat("post_reset");
    chk(so_v[0] == ones_res, "post_reset_result", $sformatf("%h", so_v[0]), $sformatf("%h", ones_res));
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
